lab1_checker: RTL and testbench

LAB1_CHECKER -- requirements
Module: lab1_checker

---
 rtl/lab1_checker.sv | 152 +++++++++++++++
 tb/tb_lab1_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_checker.sv
// rtl/lab1_checker.sv - Lab1_hello response checker: per-run coverage, mismatch count, first-error capture, timeout.
module lab1_checker #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       smp_valid,
    input  logic       tb_a,
    input  logic       tb_b,
    input  logic       tb_c,
    input  logic       L1_andOut,
    input  logic       L1_orOut,
    input  logic       L1_nandOut,
    input  logic       L1_norOut,
    input  logic       L1_notOut_a,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [3:0] err_cnt,
    output logic [7:0] cov,
    output logic [2:0] first_err_vec,
    output logic [4:0] first_err_mask
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic [7:0] LP_IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       r_tmo;
    logic       w_tmo_nxt;
    logic [3:0] r_err_cnt;
    logic [3:0] w_err_nxt;
    logic [7:0] r_cov;
    logic [7:0] w_cov_nxt;
    logic [2:0] r_fvec;
    logic [2:0] w_fvec_nxt;
    logic [4:0] r_fmask;
    logic [4:0] w_fmask_nxt;
    logic [7:0] r_idle;
    logic [7:0] w_idle_nxt;

    logic [2:0] w_vec;
    logic [7:0] w_vec_onehot;
    logic [4:0] w_exp;
    logic [4:0] w_act;
    logic [4:0] w_mask;
    logic       w_mis;

    assign w_vec        = {tb_a, tb_b, tb_c};
    assign w_vec_onehot = 8'd1 << w_vec;
    // Bit order {and, or, nand, nor, not_a} matches first_err_mask.
    assign w_exp  = {tb_a & tb_b & tb_c, tb_a | tb_b | tb_c,
                     ~(tb_a & tb_b & tb_c), ~(tb_a | tb_b | tb_c), ~tb_a};
    assign w_act  = {L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a};
    assign w_mask = w_exp ^ w_act;
    assign w_mis  = |w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err_cnt;
        w_cov_nxt   = r_cov;
        w_fvec_nxt  = r_fvec;
        w_fmask_nxt = r_fmask;
        w_idle_nxt  = r_idle;
        case (r_state)
            ST_RUN: begin
                if (smp_valid) begin
                    w_idle_nxt = 8'd0;
                    w_cov_nxt  = r_cov | w_vec_onehot;
                    if (w_mis) begin
                        // A zero count means no earlier mismatch in this run.
                        if (r_err_cnt == 4'd0) begin
                            w_fvec_nxt  = w_vec;
                            w_fmask_nxt = w_mask;
                        end
                        if (r_err_cnt != 4'hF) begin
                            w_err_nxt = r_err_cnt + 4'd1;
                        end
                    end
                    if (w_cov_nxt == 8'hFF) begin
                        w_state_nxt = (w_err_nxt == 4'd0) ? ST_PASS : ST_FAIL;
                    end
                end else if (r_idle == LP_IDLE_LIMIT) begin
                    w_state_nxt = ST_FAIL;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_idle_nxt = r_idle + 8'd1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_tmo_nxt   = 1'b0;
                    w_err_nxt   = 4'd0;
                    w_cov_nxt   = 8'd0;
                    w_fvec_nxt  = 3'd0;
                    w_fmask_nxt = 5'd0;
                    w_idle_nxt  = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_tmo     <= 1'b0;
            r_err_cnt <= 4'd0;
            r_cov     <= 8'd0;
            r_fvec    <= 3'd0;
            r_fmask   <= 5'd0;
            r_idle    <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
            r_pass    <= (w_state_nxt == ST_PASS);
            r_tmo     <= w_tmo_nxt;
            r_err_cnt <= w_err_nxt;
            r_cov     <= w_cov_nxt;
            r_fvec    <= w_fvec_nxt;
            r_fmask   <= w_fmask_nxt;
            r_idle    <= w_idle_nxt;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_tmo;
    assign err_cnt        = r_err_cnt;
    assign cov            = r_cov;
    assign first_err_vec  = r_fvec;
    assign first_err_mask = r_fmask;

endmodule

// File: tb/tb_lab1_checker.sv
// tb/tb_lab1_checker.sv - directed and random checks of lab1_checker against a behavioural model.
module tb_lab1_checker;

    localparam int TB_TIMEOUT = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       smp_valid = 1'b0;
    logic       tb_a = 1'b0;
    logic       tb_b = 1'b0;
    logic       tb_c = 1'b0;
    logic       L1_andOut = 1'b0;
    logic       L1_orOut = 1'b0;
    logic       L1_nandOut = 1'b1;
    logic       L1_norOut = 1'b1;
    logic       L1_notOut_a = 1'b1;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [3:0] err_cnt;
    logic [7:0] cov;
    logic [2:0] first_err_vec;
    logic [4:0] first_err_mask;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_mode;
    int         m_err;
    bit         m_seen [8];
    logic [2:0] m_fvec;
    logic [4:0] m_fmask;
    int         m_quiet;
    bit         m_tmo;

    lab1_checker #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .smp_valid      (smp_valid),
        .tb_a           (tb_a),
        .tb_b           (tb_b),
        .tb_c           (tb_c),
        .L1_andOut      (L1_andOut),
        .L1_orOut       (L1_orOut),
        .L1_nandOut     (L1_nandOut),
        .L1_norOut      (L1_norOut),
        .L1_notOut_a    (L1_notOut_a),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .cov            (cov),
        .first_err_vec  (first_err_vec),
        .first_err_mask (first_err_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plays the part of Lab1_hello: correct responses, with flt bits inverted.
    task automatic drive(input bit rst, input bit st, input bit v, input logic [2:0] vec,
                         input logic [4:0] flt);
        int ones;
        logic [4:0] r;
        ones = int'(vec[2]) + int'(vec[1]) + int'(vec[0]);
        r = {ones == 3, ones > 0, ones != 3, ones == 0, vec[2] == 1'b0};
        r = r ^ flt;
        reset = rst;
        start = st;
        smp_valid = v;
        {tb_a, tb_b, tb_c} = vec;
        {L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a} = r;
    endtask

    task automatic model_clear();
        m_err = 0;
        for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
        m_fvec = 3'd0;
        m_fmask = 5'd0;
        m_quiet = 0;
        m_tmo = 1'b0;
    endtask

    task automatic model_step();
        int ones;
        int n_seen;
        logic [2:0] v;
        logic [4:0] want;
        logic [4:0] got;
        if (reset) begin
            model_clear();
            m_mode = M_IDLE;
        end else if (m_mode != M_RUN) begin
            if (start) begin
                model_clear();
                m_mode = M_RUN;
            end
        end else if (smp_valid) begin
            v = {tb_a, tb_b, tb_c};
            ones = int'(tb_a) + int'(tb_b) + int'(tb_c);
            want = {ones == 3, ones > 0, ones != 3, ones == 0, !tb_a};
            got = {L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a};
            m_quiet = 0;
            m_seen[v] = 1'b1;
            if (want != got) begin
                if (m_err == 0) begin
                    m_fvec = v;
                    m_fmask = want ^ got;
                end
                m_err = (m_err >= 15) ? 15 : m_err + 1;
            end
            n_seen = 0;
            for (int i = 0; i < 8; i++) n_seen += int'(m_seen[i]);
            if (n_seen == 8) m_mode = (m_err == 0) ? M_PASS : M_FAIL;
        end else begin
            m_quiet++;
            if (m_quiet >= TB_TIMEOUT) begin
                m_mode = M_FAIL;
                m_tmo = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] c;
        for (int i = 0; i < 8; i++) c[i] = m_seen[i];
        chk("busy", busy, m_mode == M_RUN);
        chk("done", done, (m_mode == M_PASS) || (m_mode == M_FAIL));
        chk("pass", pass, m_mode == M_PASS);
        chk("timeout", timeout, m_tmo);
        chk("err_cnt", err_cnt, m_err);
        chk("cov", cov, c);
        chk("first_err_vec", first_err_vec, m_fvec);
        chk("first_err_mask", first_err_mask, m_fmask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic step(input bit rst, input bit st, input bit v, input logic [2:0] vec,
                        input logic [4:0] flt);
        drive(rst, st, v, vec, flt);
        tick();
    endtask

    initial begin
        logic [2:0] rv;
        logic [4:0] rf;
        m_mode = M_IDLE;
        model_clear();

        step(1, 0, 0, 3'd0, 5'd0);
        step(1, 1, 1, 3'd5, 5'd0);
        chk("rst_busy", busy, 0);
        chk("rst_cov", cov, 0);

        // Full correct sweep
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < 8; i++) begin
            chk("sweep_not_done_yet", done, 0);
            step(0, 0, 1, 3'(i), 5'd0);
        end
        chk("sweep_pass", pass, 1);
        chk("sweep_done", done, 1);
        chk("sweep_cov", cov, 8'hFF);
        chk("sweep_err", err_cnt, 0);

        // start in RUN ignored, start in PASS restarts
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 3'(i), 5'd0);
        step(0, 1, 0, 3'd0, 5'd0);
        chk("run_start_busy", busy, 1);
        chk("run_start_cov", cov, 8'h07);
        for (int i = 3; i < 8; i++) step(0, 0, 1, 3'(i), 5'd0);
        chk("restart_pre_pass", pass, 1);
        step(0, 1, 0, 3'd0, 5'd0);
        chk("restart_busy", busy, 1);
        chk("restart_cov", cov, 0);
        chk("restart_err", err_cnt, 0);

        // Single fault: vector 101 with or forced low
        for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), (i == 5) ? 5'b01000 : 5'b00000);
        chk("or_fault_done", done, 1);
        chk("or_fault_pass", pass, 0);
        chk("or_fault_err", err_cnt, 1);
        chk("or_fault_vec", first_err_vec, 3'b101);
        chk("or_fault_mask", first_err_mask, 5'b01000);

        // Seven vectors then silence
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 3'(i), 5'd0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step(0, 0, 0, 3'd7, 5'd0);
        chk("tmo_edge_busy", busy, 1);
        step(0, 0, 0, 3'd7, 5'd0);
        chk("tmo_fail", done & ~pass, 1);
        chk("tmo_flag", timeout, 1);
        chk("tmo_cov", cov, 8'h7F);

        // Sample on the limit cycle is accepted
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step(0, 0, 0, 3'd0, 5'd0);
        step(0, 0, 1, 3'd3, 5'd0);
        chk("limit_sample_busy", busy, 1);
        chk("limit_sample_tmo", timeout, 0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step(0, 0, 0, 3'd0, 5'd0);
        chk("limit_rearm_busy", busy, 1);
        step(0, 0, 0, 3'd0, 5'd0);
        chk("limit_rearm_tmo", timeout, 1);

        // Saturating error count
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 3'd0, 5'b10001);
        for (int i = 1; i < 8; i++) step(0, 0, 1, 3'(i), 5'd0);
        chk("sat_err", err_cnt, 15);
        chk("sat_vec", first_err_vec, 3'b000);
        chk("sat_mask", first_err_mask, 5'b10001);
        chk("sat_fail", done & ~pass, 1);

        // Mid-run reset then a clean run
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 3'(i), (i == 2) ? 5'b00100 : 5'd0);
        step(1, 1, 1, 3'd4, 5'd0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cov", cov, 0);
        chk("midrst_err", err_cnt, 0);
        step(0, 1, 0, 3'd0, 5'd0);
        for (int i = 7; i >= 0; i--) step(0, 0, 1, 3'(i), 5'd0);
        chk("midrst_pass", pass, 1);
        chk("midrst_fvec", first_err_vec, 0);
        chk("midrst_fmask", first_err_mask, 0);

        // Random traffic, dense then sparse
        for (int i = 0; i < 600; i++) begin
            rv = 3'($urandom_range(0, 7));
            rf = ($urandom_range(0, 9) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 19) == 0,
                 (i < 400) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0),
                 rv, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
